// File: rtl/regfile_sb.sv
// regfile_sb: NUM_REGS x DATA_WIDTH register file with a per-register busy
// scoreboard. It has one write port and two combinational read ports. With
// BYPASS set, a same-cycle write is forwarded to the read ports.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   wr_en/addr/data       write port; a write also clears the register's busy bit
//   rsv_en/addr           reserve port; sets the busy bit (wins over a same-cycle write)
//   ra_addr/data/busy     read port A (combinational)
//   rb_addr/data/busy     read port B (combinational)
//   busy_vec              raw scoreboard flops, never bypassed
//   rsv_overlap           registered pulse: reservation landed on an already-busy register
module regfile_sb #(
  parameter int unsigned  DATA_WIDTH = 16,
  parameter int unsigned  NUM_REGS   = 8,
  parameter int unsigned  BYPASS     = 1,
  localparam int unsigned ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rsv_en,
  input  logic [ADDR_WIDTH-1:0] rsv_addr,
  input  logic [ADDR_WIDTH-1:0] ra_addr,
  output logic [DATA_WIDTH-1:0] ra_data,
  output logic                  ra_busy,
  input  logic [ADDR_WIDTH-1:0] rb_addr,
  output logic [DATA_WIDTH-1:0] rb_data,
  output logic                  rb_busy,
  output logic [NUM_REGS-1:0]   busy_vec,
  output logic                  rsv_overlap
);

  localparam bit BYP_EN = (BYPASS != 0);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   busy;
  logic [NUM_REGS-1:0]   wr_hit;
  logic [NUM_REGS-1:0]   rsv_hit;
  logic [NUM_REGS-1:0]   busy_nxt;
  logic                  overlap_nxt;
  logic                  ra_byp;
  logic                  rb_byp;

  // One-hot decode of the write and reserve addresses
  always_comb begin
    wr_hit  = '0;
    rsv_hit = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      wr_hit[i]  = wr_en  && (wr_addr  == ADDR_WIDTH'(i));
      rsv_hit[i] = rsv_en && (rsv_addr == ADDR_WIDTH'(i));
    end
  end

  // Reservation belongs to a newer producer, so set dominates clear
  always_comb begin
    busy_nxt    = (busy & ~wr_hit) | rsv_hit;
    overlap_nxt = |(rsv_hit & busy & ~wr_hit);
  end

  // Data storage: one load-enabled word per register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (wr_hit[i]) begin
          regs[i] <= wr_data;
        end
      end
    end
  end

  // Scoreboard and overlap flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= '0;
      rsv_overlap <= 1'b0;
    end else begin
      busy        <= busy_nxt;
      rsv_overlap <= overlap_nxt;
    end
  end

  // Read ports; only the write is forwarded, a same-cycle reservation is not
  always_comb begin
    ra_byp  = BYP_EN && wr_en && (wr_addr == ra_addr);
    rb_byp  = BYP_EN && wr_en && (wr_addr == rb_addr);
    ra_data = ra_byp ? wr_data : regs[ra_addr];
    rb_data = rb_byp ? wr_data : regs[rb_addr];
    ra_busy = !ra_byp && busy[ra_addr];
    rb_busy = !rb_byp && busy[rb_addr];
  end

  assign busy_vec = busy;

endmodule
